// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_queue
// Description : Instruction fetch unit with a pipelined, in-order memory
//               request port. Up to MAX_OUT fetches can be in flight.
//               Returned instructions and their PCs are buffered in a
//               DEPTH-entry FIFO that feeds decode. A redirect flushes the
//               buffer and squashes stale responses while they are still in
//               flight, so the new stream can start without waiting for the
//               old one to drain.
//               Optional macro IFU_FETCH_QUEUE_PERF_EN adds the wrapping
//               counters perf_fetched and perf_dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [PC_W-1:0]           redirect_pc,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [PC_W-1:0]           req_addr,
  input  logic                      rsp_valid,
  input  logic [INST_W-1:0]         rsp_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_W-1:0]           out_pc,
  output logic [INST_W-1:0]         out_inst,
  output logic [$clog2(DEPTH):0]    buf_count
`ifdef IFU_FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_dropped
`endif
);

  localparam int              c_cnt_w = $clog2(DEPTH) + 1;
  localparam int              c_out_w = $clog2(MAX_OUT) + 1;
  localparam int              c_buf_iw = $clog2(DEPTH);
  localparam int              c_ifl_iw = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int              c_sum_w  = ((c_cnt_w > c_out_w) ? c_cnt_w : c_out_w) + 1;
  localparam logic [PC_W-1:0] c_step   = PC_W'(INST_W / 8);

  // Fetch PC and in-flight bookkeeping. r_out counts every request still
  // owed a response. r_drop counts how many of those belong to a squashed
  // stream and must be thrown away when they return.
  logic [PC_W-1:0]     r_pc;
  logic [c_out_w-1:0]  r_out;
  logic [c_out_w-1:0]  r_drop;

  // PCs of live (non-squashed) in-flight requests, in issue order
  logic [PC_W-1:0]     r_ifl_pc [MAX_OUT];
  logic [c_ifl_iw-1:0] r_ifl_wr;
  logic [c_ifl_iw-1:0] r_ifl_rd;

  // Instruction buffer towards decode
  logic [PC_W-1:0]     r_buf_pc   [DEPTH];
  logic [INST_W-1:0]   r_buf_inst [DEPTH];
  logic [c_buf_iw-1:0] r_wr;
  logic [c_buf_iw-1:0] r_rd;
  logic [c_cnt_w-1:0]  r_count;

  logic [c_out_w-1:0]  w_live;
  logic [c_sum_w-1:0]  w_credit;
  logic                w_req_valid;
  logic                w_req_fire;
  logic                w_rsp;
  logic                w_rsp_drop;
  logic                w_rsp_keep;
  logic                w_out_valid;
  logic                w_pop;
  logic                w_push;

  // In-flight PC FIFO pointer advance; a single-entry FIFO never moves
  function automatic logic [c_ifl_iw-1:0] ifl_next(input logic [c_ifl_iw-1:0] p);
    if (MAX_OUT == 1) return '0;
    else              return p + 1'b1;
  endfunction

  // Credit only counts live requests: squashed responses never land in the
  // buffer, so they do not need a reserved slot.
  assign w_live      = r_out - r_drop;
  assign w_credit    = c_sum_w'(r_count) + c_sum_w'(w_live);
  assign w_req_valid = ~reset & ~stall & ~redirect_valid
                     & (r_out < c_out_w'(MAX_OUT))
                     & (w_credit < c_sum_w'(DEPTH));
  assign w_req_fire  = w_req_valid & req_ready;

  // Responses with nothing outstanding are strays (e.g. after reset)
  assign w_rsp       = rsp_valid & (r_out != '0);
  assign w_rsp_drop  = w_rsp & (r_drop != '0);
  assign w_rsp_keep  = w_rsp & (r_drop == '0);

  assign w_out_valid = (r_count != '0) & ~redirect_valid;
  assign w_pop       = w_out_valid & out_ready;
  assign w_push      = w_rsp_keep & ~redirect_valid;

  assign req_valid   = w_req_valid;
  assign req_addr    = r_pc;
  assign out_valid   = w_out_valid;
  assign out_pc      = r_buf_pc[r_rd];
  assign out_inst    = r_buf_inst[r_rd];
  assign buf_count   = r_count;

  // Control state: PC, outstanding/drop counters, FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_ifl_wr <= '0;
      r_ifl_rd <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      // Everything still owed after this cycle belongs to the old stream
      r_pc     <= redirect_pc;
      r_out    <= r_out - c_out_w'(w_rsp);
      r_drop   <= r_out - c_out_w'(w_rsp);
      r_ifl_wr <= '0;
      r_ifl_rd <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
    end else begin
      if (w_req_fire) begin
        r_pc     <= r_pc + c_step;
        r_ifl_wr <= ifl_next(r_ifl_wr);
      end
      if (w_rsp_keep) begin
        r_ifl_rd <= ifl_next(r_ifl_rd);
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - 1'b1;
      end
      r_out <= r_out + c_out_w'(w_req_fire) - c_out_w'(w_rsp);
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  // Payload storage; contents are only meaningful under the valid pointers
  always_ff @(posedge clock) begin
    if (w_req_fire) begin
      r_ifl_pc[r_ifl_wr] <= r_pc;
    end
    if (w_push) begin
      r_buf_pc[r_wr]   <= r_ifl_pc[r_ifl_rd];
      r_buf_inst[r_wr] <= rsp_data;
    end
  end

`ifdef IFU_FETCH_QUEUE_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;

  // Count buffered instructions and squashed responses (incl. the one
  // arriving in a redirect cycle)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_rsp & (redirect_valid | (r_drop != '0))) begin
        r_perf_dropped <= r_perf_dropped + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_queue
// Description : Self-checking bench for ifu_fetch_queue. A queue-based model
//               tracks the fetch stream (in-flight list with live/squashed
//               flags, buffered {pc,inst} list); a simple memory returns
//               data derived from the request address. Directed scenarios
//               are followed by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_queue;

  localparam int          PC_W     = 64;
  localparam int          INST_W   = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam int          CNT_W    = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              stall;
  logic              redirect_valid;
  logic [63:0]       redirect_pc;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_pc;
  logic [31:0]       out_inst;
  logic [CNT_W-1:0]  buf_count;
`ifdef IFU_FETCH_QUEUE_PERF_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_dropped;
`endif

  always #5 clock = ~clock;

  ifu_fetch_queue #(
    .PC_W     (PC_W),
    .INST_W   (INST_W),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .buf_count      (buf_count)
`ifdef IFU_FETCH_QUEUE_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic [63:0] m_ifl_pc[$];
  bit          m_ifl_live[$];
  logic [63:0] m_buf_pc[$];
  logic [31:0] m_buf_inst[$];
  logic [31:0] m_fetched;
  logic [31:0] m_dropped;

  // Memory side: addresses accepted and not yet answered
  logic [63:0] mem_q[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC001_D00D;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (m_ifl_live[i]) if (m_ifl_live[i]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ifl_pc.delete();
    m_ifl_live.delete();
    m_buf_pc.delete();
    m_buf_inst.delete();
    m_fetched = '0;
    m_dropped = '0;
  endtask

  // Assert reset asynchronously, check the immediate reset state, release
  // on the following falling edge. The memory keeps its pending answers.
  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_buf_count", 64'(buf_count), 64'd0);
    check("rst_req_addr",  req_addr, RESET_PC);
`ifdef IFU_FETCH_QUEUE_PERF_EN
    check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    check("rst_perf_dropped", 64'(perf_dropped), 64'd0);
`endif
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance memory and model by the handshakes of this cycle.
  task automatic cycle(input bit st, input bit rd, input logic [63:0] rpc,
                       input bit rdy, input bit rsp_en, input bit ordy);
    bit          e_req;
    bit          e_out;
    bit          rsp_hit;
    logic [63:0] rsp_addr;
    logic [63:0] p;
    bit          lv;
    stall          = st;
    redirect_valid = rd;
    redirect_pc    = rpc;
    req_ready      = rdy;
    out_ready      = ordy;
    rsp_hit        = rsp_en && (mem_q.size() > 0);
    rsp_addr       = rsp_hit ? mem_q[0] : 64'd0;
    rsp_valid      = rsp_hit;
    rsp_data       = rsp_hit ? inst_of(rsp_addr) : 32'd0;
    #1;
    e_req = !st && !rd && (m_ifl_pc.size() < MAX_OUT)
            && ((m_buf_pc.size() + live_cnt()) < DEPTH);
    e_out = (m_buf_pc.size() != 0) && !rd;
    check("req_valid", 64'(req_valid), 64'(e_req));
    check("req_addr",  req_addr, m_pc);
    check("out_valid", 64'(out_valid), 64'(e_out));
    check("buf_count", 64'(buf_count), 64'(m_buf_pc.size()));
    if (e_out) begin
      check("out_pc",   out_pc, m_buf_pc[0]);
      check("out_inst", 64'(out_inst), 64'(m_buf_inst[0]));
    end
`ifdef IFU_FETCH_QUEUE_PERF_EN
    check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
    check("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
`endif
    // memory
    if (rsp_hit) void'(mem_q.pop_front());
    if (req_valid && rdy) mem_q.push_back(req_addr);
    // model
    if (rd) begin
      m_pc = rpc;
      m_buf_pc.delete();
      m_buf_inst.delete();
      if (rsp_hit && (m_ifl_pc.size() > 0)) begin
        void'(m_ifl_pc.pop_front());
        void'(m_ifl_live.pop_front());
        m_dropped = m_dropped + 32'd1;
      end
      foreach (m_ifl_live[i]) m_ifl_live[i] = 1'b0;
    end else begin
      if (e_out && ordy) begin
        void'(m_buf_pc.pop_front());
        void'(m_buf_inst.pop_front());
      end
      if (rsp_hit && (m_ifl_pc.size() > 0)) begin
        p  = m_ifl_pc.pop_front();
        lv = m_ifl_live.pop_front();
        if (lv) begin
          m_buf_pc.push_back(p);
          m_buf_inst.push_back(rsp_data);
          m_fetched = m_fetched + 32'd1;
        end else begin
          m_dropped = m_dropped + 32'd1;
        end
      end
      if (e_req && rdy) begin
        m_ifl_pc.push_back(m_pc);
        m_ifl_live.push_back(1'b1);
        m_pc = m_pc + 64'(INST_W / 8);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [63:0] pc_before;
    logic [63:0] rp;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Streaming with a 1-cycle memory: one fetch per cycle
    check("tp1_first_addr", req_addr, 64'h8000_0000);
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 1, 1, 1);
    check("tp1_pc_after8", req_addr, 64'h8000_0020);

    // Back-pressure from decode fills the buffer and stops issue
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1, 1, 0);
    check("tp2_full_count", 64'(buf_count), 64'd4);
    pc_before = req_addr;
    cycle(0, 0, '0, 1, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, 1, 0);
    check("tp2_one_refill", req_addr, pc_before + 64'd4);
    check("tp2_full_again", 64'(buf_count), 64'd4);
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, 0, 1, 1);
    check("tp2_drained", 64'(buf_count), 64'd0);

    // Redirect with two requests in flight (0x...08 and 0x...0C)
    do_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 1, 0, 0);
    check("tp3_pc_before_redirect", req_addr, 64'h8000_0010);
    cycle(0, 1, 64'h8000_1000, 1, 0, 0);
    check("tp3_pc_redirected", req_addr, 64'h8000_1000);
    check("tp3_flushed", 64'(buf_count), 64'd0);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 1, 0);
    check("tp3_head_pc", out_pc, 64'h8000_1000);
`ifdef IFU_FETCH_QUEUE_PERF_EN
    check("tp3_perf_dropped", 64'(perf_dropped), 64'd2);
`endif
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1, 1, 1);

    // Redirect coinciding with a response while two are outstanding
    do_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 1, 0, 0);
    cycle(0, 1, 64'h8000_2000, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, 1, 0);
    check("tp4_full", 64'(buf_count), 64'd4);
    check("tp4_head_pc", out_pc, 64'h8000_2000);
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1, 1, 1);

    // Stall while a 3-cycle memory still returns pending data
    do_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 1, 0, 0);
    cycle(1, 0, '0, 1, 0, 0);
    cycle(1, 0, '0, 1, 0, 0);
    cycle(1, 0, '0, 1, 1, 0);
    cycle(1, 0, '0, 1, 1, 0);
    cycle(1, 0, '0, 1, 0, 0);
    check("tp5_pc_held", req_addr, 64'h8000_0008);
    check("tp5_buffered", 64'(buf_count), 64'd2);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 1, 1);

    // Reset with two outstanding, then stray responses are ignored
    do_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, '0, 0, 1, 1);
    check("tp6_stray_count", 64'(buf_count), 64'd0);
    check("tp6_stray_pc", req_addr, RESET_PC);

    // PC wraps modulo 2^64
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, '0, 1, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        mem_q.delete();
      end else begin
        rp = {$urandom, $urandom} & ~64'h3;
        cycle($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, rp,
              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) < 6);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
